// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns byte/half/word accesses into full-word memory cycles, with read-modify-write for SB/SH.
// Done comes 3 cycles after accept for loads, 2 for SW, 4 for SB/SH and 1 for faults; lsu_ready is high only in IDLE.
module load_store_unit #(
   parameter int MEM_ADDR_BITS = 12
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        lsu_valid,
   output logic        lsu_ready,
   input  logic        lsu_we,
   input  logic [2:0]  lsu_funct3,
   input  logic [31:0] lsu_base,
   input  logic [31:0] lsu_offset,
   input  logic [31:0] lsu_wdata,
   output logic        lsu_done,
   output logic [31:0] lsu_rdata,
   output logic        lsu_exc,
   output logic [1:0]  lsu_exc_cause,
   output logic        data_mem_req,
   output logic        data_mem_wr,
   output logic [31:0] data_mem_addr,
   output logic [31:0] data_mem_wr_data,
   output logic [1:0]  data_mem_byte_en,
   input  logic [31:0] mem_rd_data
);

   typedef enum logic [2:0] {
      IDLE,
      LD_REQ,
      LD_WAIT,
      RMW_RD,
      RMW_WAIT,
      ST_WR
   } state_t;

   // Operands latched at accept; only the low half of the store data is needed for SB/SH merges.
   typedef struct packed {
      logic [31:0] ea;
      logic [2:0]  funct3;
      logic [15:0] wdata;
   } op_t;

   localparam logic [1:0] CAUSE_NONE  = 2'b00;
   localparam logic [1:0] CAUSE_ALIGN = 2'b01;
   localparam logic [1:0] CAUSE_RANGE = 2'b10;
   localparam logic [1:0] CAUSE_ILL   = 2'b11;

   state_t      state;
   op_t         op;
   logic [31:0] wr_word;
   logic [31:0] ea_in;
   logic [1:0]  cause_in;
   logic        illegal_in;
   logic        misalign_in;

   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         3'b000:  r = {{24{b[7]}}, b};
         3'b001:  r = {{16{h[15]}}, h};
         3'b100:  r = {24'd0, b};
         3'b101:  r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  size,
                                               input logic [15:0] wd);
      logic [31:0] r;
      r = word;
      if (size == 2'b00) begin
         case (off)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end else if (off[1]) begin
         r[31:16] = wd;
      end else begin
         r[15:0] = wd;
      end
      return r;
   endfunction

   always_comb begin
      ea_in = lsu_base + lsu_offset;
      if (lsu_we)
         illegal_in = lsu_funct3[2] || (lsu_funct3[1:0] == 2'b11);
      else
         illegal_in = (lsu_funct3[1:0] == 2'b11) || (lsu_funct3 == 3'b110);
      misalign_in = ((lsu_funct3[1:0] == 2'b01) && ea_in[0]) ||
                    ((lsu_funct3[1:0] == 2'b10) && (ea_in[1:0] != 2'b00));
      cause_in = CAUSE_NONE;
      if (illegal_in)
         cause_in = CAUSE_ILL;
      else if (misalign_in)
         cause_in = CAUSE_ALIGN;
      else if (|ea_in[31:MEM_ADDR_BITS])
         cause_in = CAUSE_RANGE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         op            <= '0;
         wr_word       <= '0;
         lsu_done      <= 1'b0;
         lsu_exc       <= 1'b0;
         lsu_exc_cause <= CAUSE_NONE;
         lsu_rdata     <= '0;
      end else begin
         lsu_done      <= 1'b0;
         lsu_exc       <= 1'b0;
         lsu_exc_cause <= CAUSE_NONE;
         case (state)
            IDLE: begin
               if (lsu_valid) begin
                  op.ea     <= ea_in;
                  op.funct3 <= lsu_funct3;
                  op.wdata  <= lsu_wdata[15:0];
                  if (cause_in != CAUSE_NONE) begin
                     lsu_done      <= 1'b1;
                     lsu_exc       <= 1'b1;
                     lsu_exc_cause <= cause_in;
                  end else if (!lsu_we) begin
                     state <= LD_REQ;
                  end else if (lsu_funct3[1:0] == 2'b10) begin
                     wr_word <= lsu_wdata;
                     state   <= ST_WR;
                  end else begin
                     state <= RMW_RD;
                  end
               end
            end
            LD_REQ:   state <= LD_WAIT;
            LD_WAIT: begin
               lsu_rdata <= load_extend(mem_rd_data, op.ea[1:0], op.funct3);
               lsu_done  <= 1'b1;
               state     <= IDLE;
            end
            RMW_RD:   state <= RMW_WAIT;
            RMW_WAIT: begin
               wr_word <= store_merge(mem_rd_data, op.ea[1:0], op.funct3[1:0], op.wdata);
               state   <= ST_WR;
            end
            ST_WR: begin
               lsu_done <= 1'b1;
               state    <= IDLE;
            end
            default:  state <= IDLE;
         endcase
      end
   end

   assign lsu_ready        = (state == IDLE);
   assign data_mem_req     = (state == LD_REQ) || (state == RMW_RD) || (state == ST_WR);
   assign data_mem_wr      = (state == ST_WR);
   assign data_mem_addr    = {op.ea[31:2], 2'b00};
   assign data_mem_wr_data = wr_word;
   assign data_mem_byte_en = 2'b11;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered word-addressed memory model.
// Latency measured from accept edge to lsu_done; memory model answers one cycle after a read request.
// Requests are held until lsu_ready; the memory model never stalls.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lsu_valid;
    logic        lsu_ready;
    logic        lsu_we;
    logic [2:0]  lsu_funct3;
    logic [31:0] lsu_base;
    logic [31:0] lsu_offset;
    logic [31:0] lsu_wdata;
    logic        lsu_done;
    logic [31:0] lsu_rdata;
    logic        lsu_exc;
    logic [1:0]  lsu_exc_cause;
    logic        data_mem_req;
    logic        data_mem_wr;
    logic [31:0] data_mem_addr;
    logic [31:0] data_mem_wr_data;
    logic [1:0]  data_mem_byte_en;
    logic [31:0] mem_rd_data = 32'd0;

    int vectors = 0;
    int miscompares = 0;
    int lat;
    int req_before;
    int wr_before;

    logic [31:0] mem [0:1023];
    int          wr_cnt = 0;
    int          req_cnt = 0;
    logic [31:0] last_wr_addr;
    logic [31:0] last_wr_data;
    logic [1:0]  last_wr_be;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_ADDR_BITS(12)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .lsu_valid        (lsu_valid),
        .lsu_ready        (lsu_ready),
        .lsu_we           (lsu_we),
        .lsu_funct3       (lsu_funct3),
        .lsu_base         (lsu_base),
        .lsu_offset       (lsu_offset),
        .lsu_wdata        (lsu_wdata),
        .lsu_done         (lsu_done),
        .lsu_rdata        (lsu_rdata),
        .lsu_exc          (lsu_exc),
        .lsu_exc_cause    (lsu_exc_cause),
        .data_mem_req     (data_mem_req),
        .data_mem_wr      (data_mem_wr),
        .data_mem_addr    (data_mem_addr),
        .data_mem_wr_data (data_mem_wr_data),
        .data_mem_byte_en (data_mem_byte_en),
        .mem_rd_data      (mem_rd_data)
    );

    always @(posedge clk) begin
        if (data_mem_req) begin
            req_cnt <= req_cnt + 1;
            if (data_mem_wr) begin
                mem[data_mem_addr[11:2]] <= data_mem_wr_data;
                wr_cnt       <= wr_cnt + 1;
                last_wr_addr <= data_mem_addr;
                last_wr_data <= data_mem_wr_data;
                last_wr_be   <= data_mem_byte_en;
            end else begin
                mem_rd_data <= mem[data_mem_addr[11:2]];
            end
        end
    end

    task automatic chk(input string tag, input bit ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd);
        int n;
        lsu_valid  = 1'b1;
        lsu_we     = we;
        lsu_funct3 = f3;
        lsu_base   = base;
        lsu_offset = off;
        lsu_wdata  = wd;
        n = 0;
        while (!lsu_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        req_before = req_cnt;
        wr_before  = wr_cnt;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        lat = 1;
        while (!lsu_done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic chk_fault(input string tag, input logic [1:0] cause);
        chk({tag, "_lat"}, lat == 1);
        chk({tag, "_exc"}, lsu_exc === 1'b1);
        chk({tag, "_cause"}, lsu_exc_cause === cause);
        chk({tag, "_noreq"}, (req_cnt - req_before + int'(data_mem_req)) == 0);
        @(posedge clk); #1;
        chk({tag, "_clear"}, {lsu_done, lsu_exc, lsu_exc_cause} === 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        lsu_valid  = 1'b0;
        lsu_we     = 1'b0;
        lsu_funct3 = 3'b000;
        lsu_base   = 32'd0;
        lsu_offset = 32'd0;
        lsu_wdata  = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", lsu_ready === 1'b1);
        chk("rst_done_exc_cause", {lsu_done, lsu_exc, lsu_exc_cause} === 4'b0000);
        chk("rst_rdata", lsu_rdata === 32'd0);
        chk("rst_req_wr", {data_mem_req, data_mem_wr} === 2'b00);
        chk("rst_addr", data_mem_addr === 32'd0);
        chk("rst_wr_data", data_mem_wr_data === 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        do_req(1'b1, 3'b010, 32'h100, 32'h4, 32'hDEADBEEF);
        chk("sw_lat", lat == 2);
        chk("sw_exc", lsu_exc === 1'b0);
        chk("sw_addr", last_wr_addr === 32'h104);
        chk("sw_data", last_wr_data === 32'hDEADBEEF);
        chk("sw_be", last_wr_be === 2'b11);
        chk("sw_one_write", (wr_cnt - wr_before) == 1);
        do_req(1'b0, 3'b010, 32'h100, 32'h4, 32'h0);
        chk("lw_lat", lat == 3);
        chk("lw_rdata", lsu_rdata === 32'hDEADBEEF);
        chk("lw_exc", lsu_exc === 1'b0);

        do_req(1'b1, 3'b010, 32'h200, 32'h0, 32'h80FF7F01);
        do_req(1'b0, 3'b000, 32'h200, 32'h2, 32'h0);
        chk("lb_202", lsu_rdata === 32'hFFFFFFFF);
        do_req(1'b0, 3'b100, 32'h204, 32'hFFFFFFFE, 32'h0);
        chk("lbu_202_negoff", lsu_rdata === 32'h000000FF);
        do_req(1'b0, 3'b001, 32'h200, 32'h2, 32'h0);
        chk("lh_202", lsu_rdata === 32'hFFFF80FF);
        do_req(1'b0, 3'b101, 32'h200, 32'h2, 32'h0);
        chk("lhu_202", lsu_rdata === 32'h000080FF);
        do_req(1'b0, 3'b000, 32'h200, 32'h0, 32'h0);
        chk("lb_200", lsu_rdata === 32'h00000001);
        do_req(1'b0, 3'b100, 32'h200, 32'h1, 32'h0);
        chk("lbu_201", lsu_rdata === 32'h0000007F);
        do_req(1'b0, 3'b000, 32'h200, 32'h0, 32'h0);

        do_req(1'b1, 3'b010, 32'h300, 32'h0, 32'h11223344);
        do_req(1'b1, 3'b000, 32'h300, 32'h1, 32'hFFFFFFAA);
        chk("sb_lat", lat == 4);
        chk("sb_addr", last_wr_addr === 32'h300);
        chk("sb_data", last_wr_data === 32'h1122AA44);
        chk("sb_rdata_held", lsu_rdata === 32'h00000001);
        do_req(1'b1, 3'b001, 32'h300, 32'h2, 32'h1234BEEF);
        chk("sh_lat", lat == 4);
        chk("sh_data", last_wr_data === 32'hBEEFAA44);

        do_req(1'b0, 3'b010, 32'h100, 32'h2, 32'h0);
        chk("lw_mis_rdata_held", lsu_rdata === 32'h00000001);
        chk_fault("lw_mis", 2'b01);
        do_req(1'b0, 3'b001, 32'h1000, 32'h1, 32'h0);
        chk_fault("lh_mis_over_range", 2'b01);
        do_req(1'b1, 3'b010, 32'h1000, 32'h0, 32'h12345678);
        chk_fault("sw_range", 2'b10);
        chk("sw_range_nowrite", (wr_cnt - wr_before) == 0);
        do_req(1'b0, 3'b011, 32'h100, 32'h0, 32'h0);
        chk_fault("ld_f3_011", 2'b11);
        do_req(1'b0, 3'b111, 32'h1003, 32'h0, 32'h0);
        chk_fault("ld_f3_111_ill_first", 2'b11);
        do_req(1'b1, 3'b100, 32'h100, 32'h0, 32'h0);
        chk_fault("st_f3_100", 2'b11);

        do_req(1'b0, 3'b010, 32'h104, 32'h0, 32'h0);
        chk("b2b_lw_rdata", lsu_rdata === 32'hDEADBEEF);
        chk("b2b_ready_in_done", lsu_ready === 1'b1);
        lsu_valid  = 1'b1;
        lsu_we     = 1'b1;
        lsu_funct3 = 3'b010;
        lsu_base   = 32'h108;
        lsu_offset = 32'h0;
        lsu_wdata  = 32'hCAFEF00D;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        chk("b2b_st_wr_next", {data_mem_req, data_mem_wr} === 2'b11);
        chk("b2b_st_addr", data_mem_addr === 32'h108);
        @(posedge clk); #1;
        chk("b2b_sw_done", {lsu_done, lsu_exc} === 2'b10);
        chk("b2b_sw_data", last_wr_data === 32'hCAFEF00D);

        lsu_valid  = 1'b1;
        lsu_we     = 1'b1;
        lsu_funct3 = 3'b000;
        lsu_base   = 32'h300;
        lsu_offset = 32'h1;
        lsu_wdata  = 32'h00000055;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        chk("rmw_rd_req", {data_mem_req, data_mem_wr} === 2'b10);
        @(posedge clk); #1;
        wr_before = wr_cnt;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_req", data_mem_req === 1'b0);
        chk("rst_mid_rdata", lsu_rdata === 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_nowrite", (wr_cnt - wr_before) == 0);
        do_req(1'b0, 3'b010, 32'h300, 32'h0, 32'h0);
        chk("rst_mid_readback", lsu_rdata === 32'hBEEFAA44);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the RV32I execute stage and the word-addressed data memory, directly upstream of it.
- Computes the effective address and checks alignment, range and funct3 legality.
- Converts LB/LH/LW/LBU/LHU/SB/SH/SW into full-word memory transactions; SB/SH become read-modify-write.
- Returns sign- or zero-extended load data to the pipeline with a one-cycle done pulse.

Parameters:
MEM_ADDR_BITS, 12, byte-address bits backed by data memory; effective addresses at or above 2**MEM_ADDR_BITS fault.

Ports:
clk  in  1  core clock
reset_n  in  1  asynchronous active-low reset
lsu_valid  in  1  request present
lsu_ready  out  1  high only in IDLE; request accepted on clock edge when lsu_valid && lsu_ready
lsu_we  in  1  1=store, 0=load
lsu_funct3  in  3  RV32I funct3
lsu_base  in  32  rs1 value
lsu_offset  in  32  sign-extended immediate
lsu_wdata  in  32  rs2 value
lsu_done  out  1  one-cycle completion pulse
lsu_rdata  out  32  extended load result, held until next load completes
lsu_exc  out  1  exception, valid with lsu_done
lsu_exc_cause  out  2  01 misaligned, 10 out of range, 11 illegal funct3
data_mem_req  out  1  memory request
data_mem_wr  out  1  1=write
data_mem_addr  out  32  word-aligned address {ea[31:2],2'b00}
data_mem_wr_data  out  32  full write word
data_mem_byte_en  out  2  always 2'b11 (full word)
mem_rd_data  in  32  memory read data, registered, valid the cycle after a read request

Behaviour:
- Reset values: lsu_done=0, lsu_exc=0, lsu_exc_cause=00, lsu_rdata=0, req=0, wr=0, addr=0, wr_data=0; state=IDLE.
- Reset mid-operation abandons the access; no write is issued after reset_n rises.
- Memory interface outputs decode from registered state and latched operands only; no input-to-output combinational paths.
- Effective address: ea = lsu_base + lsu_offset, 32-bit modulo, latched at accept.
- Exception checks at accept, priority high to low:
  - Illegal: load funct3 in {011,110,111}, or store funct3 not in {000,001,010}.
  - Misaligned: half access with ea[0]=1, or word access with ea[1:0]!=0.
  - Out of range: ea >= 2**MEM_ADDR_BITS.
- Faulting request: no memory access; lsu_done=1, lsu_exc=1, cause set, in the cycle after the accept edge; state stays IDLE; lsu_rdata unchanged.
- lsu_exc and lsu_exc_cause clear with lsu_done.
- States:
  - IDLE: ready=1, req=0. Legal load -> LD_REQ; SW -> ST_WR with wr_data=lsu_wdata; SB/SH -> RMW_RD.
  - LD_REQ: req=1, wr=0 -> LD_WAIT.
  - LD_WAIT: select lane from mem_rd_data by ea[1:0] (byte) or ea[1] (half). LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through. Edge registers lsu_rdata and sets lsu_done -> IDLE.
  - RMW_RD: req=1, wr=0 -> RMW_WAIT.
  - RMW_WAIT: merge lsu_wdata[7:0] into byte lane ea[1:0], or lsu_wdata[15:0] into half lane ea[1]; other bytes taken from mem_rd_data. Edge registers merged word -> ST_WR.
  - ST_WR: req=1, wr=1, byte_en=11 -> IDLE with lsu_done=1.
- Latency from accept edge to lsu_done high: load 3 cycles, SW 2 cycles, SB/SH 4 cycles, fault 1 cycle.
- lsu_ready is high in the lsu_done cycle, so back-to-back requests are accepted with no bubble.
- lsu_valid while not ready is ignored; the upstream stage holds the request until accepted.
- Lane extraction reads mem_rd_data only in LD_WAIT and RMW_WAIT.

Test Plan:
- SW base=0x100 off=0x4 wdata=0xDEADBEEF, then LW same address -> write at data_mem_addr=0x104 with byte_en=11; load lsu_rdata=0xDEADBEEF, lsu_done 3 cycles after accept, lsu_exc=0.
- Word 0x80FF7F01 at 0x200: LB/LBU at 0x202 -> 0xFFFFFFFF/0x000000FF; LH/LHU at 0x202 -> 0xFFFF80FF/0x000080FF; LB at 0x200 -> 0x00000001.
- Word 0x11223344 at 0x300: SB wdata=0xAA at 0x301 -> read, then write 0x1122AA44 at edge 3, done at 4; SH wdata=0xBEEF at 0x302 -> 0xBEEFAA44.
- LW at 0x102 -> cause 01; LH at 0x1001 -> cause 01 (misaligned beats range); SW at 0x1000 -> cause 10; load funct3=011 -> cause 11. All: done 1 cycle after accept, req never asserted.
- Assert reset_n low during RMW_WAIT of an SB -> req=0 immediately, no write follows; memory word unchanged on readback.
- Issue LW, then SW the cycle lsu_done rises with lsu_valid held -> second request accepted that edge, no idle cycle between transactions.
